// File: rtl/qar_mem_arbiter.sv
// rtl/qar_mem_arbiter.sv - shares one memory port between QAR-Core fetch and data requesters
// Optional feature macro: QAR_ARB_ROUND_ROBIN_EN (strict alternation instead of data priority)
module qar_mem_arbiter #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MAX_IWAIT  = 4,
    parameter int                    TIMEOUT    = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA  = 'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_valid,
    input  logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_ready,
    output logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  mem_valid,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  ext_valid,
    output logic                  ext_we,
    output logic [ADDR_WIDTH-1:0] ext_addr,
    output logic [DATA_WIDTH-1:0] ext_wdata,
    input  logic                  ext_ready,
    input  logic [DATA_WIDTH-1:0] ext_rdata,
    output logic                  owner_d,
    output logic                  bus_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // Last ISSUE cycle count before the access is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_timer;
    logic       w_any_req;
    logic       w_grant_d;

    assign w_any_req = imem_valid | mem_valid;

`ifdef QAR_ARB_ROUND_ROBIN_EN
    // Alternate on contention: data wins only if the previous owner was instruction.
    always_comb begin
        w_grant_d = mem_valid & (~imem_valid | ~owner_d);
    end
`else
    localparam logic [3:0] IWAIT_MAX = 4'(MAX_IWAIT);

    logic [3:0] r_iwait;

    // Data wins unless a waiting fetch has already been passed over MAX_IWAIT times.
    always_comb begin
        w_grant_d = mem_valid & ~(imem_valid & (r_iwait == IWAIT_MAX));
    end

    // Count data grants that overtook a pending fetch; any fetch grant clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iwait <= '0;
        end else if ((r_state == S_IDLE) && w_any_req) begin
            if (!w_grant_d) begin
                r_iwait <= '0;
            end else if (imem_valid && (r_iwait != IWAIT_MAX)) begin
                r_iwait <= r_iwait + 4'd1;
            end
        end
    end
`endif

    // Transaction FSM: latch winner, hold request until slave completes or timer expires, pulse ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            ext_valid  <= 1'b0;
            ext_we     <= 1'b0;
            ext_addr   <= '0;
            ext_wdata  <= '0;
            imem_ready <= 1'b0;
            mem_ready  <= 1'b0;
            imem_rdata <= '0;
            mem_rdata  <= '0;
            owner_d    <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            imem_ready <= 1'b0;
            mem_ready  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        owner_d   <= w_grant_d;
                        ext_valid <= 1'b1;
                        ext_we    <= w_grant_d & mem_we;
                        ext_addr  <= w_grant_d ? mem_addr : imem_addr;
                        ext_wdata <= w_grant_d ? mem_wdata : '0;
                        r_timer   <= '0;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ext_ready || (r_timer == TMO_LAST)) begin
                        // A late completion still wins over the timeout in the same cycle.
                        if (owner_d) begin
                            mem_rdata <= ext_ready ? ext_rdata : ERR_RDATA;
                            mem_ready <= 1'b1;
                        end else begin
                            imem_rdata <= ext_ready ? ext_rdata : ERR_RDATA;
                            imem_ready <= 1'b1;
                        end
                        if (!ext_ready) begin
                            bus_err <= 1'b1;
                        end
                        ext_valid <= 1'b0;
                        r_state   <= S_RESP;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_RESP: begin
                    r_timer <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qar_mem_arbiter.sv
// tb/tb_qar_mem_arbiter.sv - self-checking bench for qar_mem_arbiter
`timescale 1ns/1ps
module tb_qar_mem_arbiter;

    localparam int MAXI = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_addr = '0;
    wire         imem_ready;
    wire  [31:0] imem_rdata;
    logic        mem_valid = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    wire         mem_ready;
    wire  [31:0] mem_rdata;
    wire         ext_valid;
    wire         ext_we;
    wire  [31:0] ext_addr;
    wire  [31:0] ext_wdata;
    wire         ext_ready;
    logic [31:0] ext_rdata = '0;
    wire         owner_d;
    wire         bus_err;

    logic        slv_ready = 1'b0;
    logic        s_force = 1'b0;
    int          s_wait = 0;
    int          s_cnt = 0;
    logic [31:0] sram [0:63];

    int          n_tests = 0;
    int          n_fail = 0;
    logic        m_owner = 1'b0;
    int          m_iw = 0;
    logic        m_berr = 1'b0;
    string       g_order = "";

    qar_mem_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MAX_IWAIT (MAXI),
        .TIMEOUT   (TMO),
        .ERR_RDATA (32'h0000_0013)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_valid(imem_valid),
        .imem_addr (imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .ext_valid (ext_valid),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_ready (ext_ready),
        .ext_rdata (ext_rdata),
        .owner_d   (owner_d),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    assign ext_ready = slv_ready | s_force;

    // Word SRAM slave answering after s_wait ISSUE cycles (s_wait < 0: never answers).
    always @(negedge clk) begin
        if (ext_valid && !slv_ready) begin
            if (s_wait >= 0 && s_cnt == s_wait) begin
                slv_ready = 1'b1;
                ext_rdata = sram[ext_addr[7:2]];
                if (ext_we) sram[ext_addr[7:2]] = ext_wdata;
                s_cnt = 0;
            end else begin
                s_cnt = s_cnt + 1;
            end
        end else begin
            slv_ready = 1'b0;
            s_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input string obs, input string exp);
        n_tests++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %s expected %s", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_valid = 1'b0;
        mem_valid = 1'b0;
        mem_we = 1'b0;
        s_force = 1'b0;
        m_owner = 1'b0;
        m_iw = 0;
        m_berr = 1'b0;
        g_order = "";
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Transaction-level model: requesters raise requests with the given percent chance,
    // the model picks the winner from the arbitration rules and checks every completion.
    task automatic run(input int ncyc, input int pi, input int pd, input int wmax);
        bit          i_p = 0;
        bit          d_p = 0;
        bit          busy = 0;
        bit          ed = 0;
        bit          ewe = 0;
        logic [31:0] ea = '0;
        logic [31:0] ew = '0;
        logic [31:0] erd = '0;
        int          age = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (busy) begin
                age++;
                if (age == 1) begin
                    chk("ext_valid", {31'd0, ext_valid}, 32'd1);
                    chk("ext_addr", ext_addr, ea);
                    chk("ext_we", {31'd0, ext_we}, {31'd0, ewe});
                    chk("owner_d", {31'd0, owner_d}, {31'd0, ed});
                    if (ewe) chk("ext_wdata", ext_wdata, ew);
                end
                if (imem_ready || mem_ready || age > wmax + 3) begin
                    chk("ready_pair", {30'd0, imem_ready, mem_ready}, ed ? 32'd1 : 32'd2);
                    if (!ewe) chk("rdata", ed ? mem_rdata : imem_rdata, erd);
                    chk("bus_err", {31'd0, bus_err}, {31'd0, m_berr});
                    if (ed) begin
                        d_p = 0;
                        mem_valid = 1'b0;
                    end else begin
                        i_p = 0;
                        imem_valid = 1'b0;
                    end
                    g_order = {g_order, ed ? "D" : "I"};
                    busy = 0;
                end
            end else begin
                if (!i_p && $urandom_range(99, 0) < pi) begin
                    i_p = 1;
                    imem_valid = 1'b1;
                    imem_addr = {24'd0, 6'($urandom), 2'b00};
                end
                if (!d_p && $urandom_range(99, 0) < pd) begin
                    d_p = 1;
                    mem_valid = 1'b1;
                    mem_we = 1'($urandom);
                    mem_addr = {24'd0, 6'($urandom), 2'b00};
                    mem_wdata = $urandom;
                end
                if (i_p || d_p) begin
`ifdef QAR_ARB_ROUND_ROBIN_EN
                    ed = d_p && (!i_p || !m_owner);
`else
                    ed = d_p && !(i_p && m_iw == MAXI);
                    if (ed && i_p) m_iw = (m_iw < MAXI) ? m_iw + 1 : MAXI;
                    if (!ed) m_iw = 0;
`endif
                    m_owner = ed;
                    ewe = ed && mem_we;
                    ea = ed ? mem_addr : imem_addr;
                    ew = mem_wdata;
                    erd = sram[ea[7:2]];
                    s_wait = $urandom_range(wmax, 0);
                    busy = 1;
                    age = 0;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) sram[i] = $urandom;
        sram[4] = 32'h0050_0093;

        // Reset state
        do_reset();
        chk("rst_ext_valid", {31'd0, ext_valid}, 32'd0);
        chk("rst_ext_we", {31'd0, ext_we}, 32'd0);
        chk("rst_ext_addr", ext_addr, 32'd0);
        chk("rst_ext_wdata", ext_wdata, 32'd0);
        chk("rst_imem_ready", {31'd0, imem_ready}, 32'd0);
        chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst_imem_rdata", imem_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_owner_d", {31'd0, owner_d}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);

        // Fetch only, zero-wait slave
        imem_valid = 1'b1; imem_addr = 32'h10; s_wait = 0;
        @(negedge clk);
        chk("fetch_c1_ext_valid", {31'd0, ext_valid}, 32'd1);
        chk("fetch_c1_ext_addr", ext_addr, 32'h10);
        chk("fetch_c1_ext_we", {31'd0, ext_we}, 32'd0);
        chk("fetch_c1_owner_d", {31'd0, owner_d}, 32'd0);
        @(negedge clk);
        chk("fetch_c2_imem_ready", {31'd0, imem_ready}, 32'd1);
        chk("fetch_c2_imem_rdata", imem_rdata, 32'h0050_0093);
        chk("fetch_c2_mem_ready", {31'd0, mem_ready}, 32'd0);
        imem_valid = 1'b0;
        @(negedge clk);
        chk("fetch_c3_imem_ready", {31'd0, imem_ready}, 32'd0);

        // Data write, two wait cycles
        mem_valid = 1'b1; mem_we = 1'b1; mem_addr = 32'h20; mem_wdata = 32'hA5A5_A5A5; s_wait = 2;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("wr_ext_valid", {31'd0, ext_valid}, 32'd1);
            chk("wr_ext_we", {31'd0, ext_we}, 32'd1);
            chk("wr_ext_addr", ext_addr, 32'h20);
            chk("wr_ext_wdata", ext_wdata, 32'hA5A5_A5A5);
            chk("wr_mem_ready_early", {31'd0, mem_ready}, 32'd0);
        end
        @(negedge clk);
        chk("wr_mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("wr_imem_ready", {31'd0, imem_ready}, 32'd0);
        mem_valid = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        chk("wr_mem_ready_once", {31'd0, mem_ready}, 32'd0);

        // Timeout: slave never answers
        imem_valid = 1'b1; imem_addr = 32'h30; s_wait = -1;
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            chk("tmo_ext_valid", {31'd0, ext_valid}, 32'd1);
            chk("tmo_imem_ready_early", {31'd0, imem_ready}, 32'd0);
        end
        @(negedge clk);
        chk("tmo_imem_ready", {31'd0, imem_ready}, 32'd1);
        chk("tmo_imem_rdata", imem_rdata, 32'h0000_0013);
        chk("tmo_bus_err", {31'd0, bus_err}, 32'd1);
        imem_valid = 1'b0;
        @(negedge clk);

        // Good read after timeout keeps bus_err sticky
        mem_valid = 1'b1; mem_we = 1'b0; mem_addr = 32'h20; s_wait = 0;
        @(negedge clk);
        @(negedge clk);
        chk("post_tmo_mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("post_tmo_mem_rdata", mem_rdata, 32'hA5A5_A5A5);
        chk("post_tmo_bus_err", {31'd0, bus_err}, 32'd1);
        mem_valid = 1'b0;
        @(negedge clk);

        // Reset during ISSUE
        mem_valid = 1'b1; mem_we = 1'b0; mem_addr = 32'h20; s_wait = 5;
        @(negedge clk);
        chk("rst_issue_ext_valid_pre", {31'd0, ext_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_issue_ext_valid", {31'd0, ext_valid}, 32'd0);
        chk("rst_issue_mem_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst_issue_imem_ready", {31'd0, imem_ready}, 32'd0);
        chk("rst_issue_bus_err", {31'd0, bus_err}, 32'd0);
        mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        imem_valid = 1'b1; imem_addr = 32'h10; s_wait = 0;
        @(negedge clk);
        chk("after_rst_ext_valid", {31'd0, ext_valid}, 32'd1);
        @(negedge clk);
        chk("after_rst_imem_ready", {31'd0, imem_ready}, 32'd1);
        chk("after_rst_imem_rdata", imem_rdata, 32'h0050_0093);
        imem_valid = 1'b0;
        @(negedge clk);

        // Stray ext_ready while idle
        s_force = 1'b1;
        @(negedge clk);
        s_force = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("late_imem_ready", {31'd0, imem_ready}, 32'd0);
            chk("late_mem_ready", {31'd0, mem_ready}, 32'd0);
            chk("late_ext_valid", {31'd0, ext_valid}, 32'd0);
            @(negedge clk);
        end
        imem_valid = 1'b1; imem_addr = 32'h10; s_wait = 0;
        @(negedge clk);
        chk("late_next_ext_valid", {31'd0, ext_valid}, 32'd1);
        @(negedge clk);
        chk("late_next_imem_ready", {31'd0, imem_ready}, 32'd1);
        imem_valid = 1'b0;

        // Both requesters continuously busy: grant order
        do_reset();
        run(30, 100, 100, 0);
`ifdef QAR_ARB_ROUND_ROBIN_EN
        chk_s("grant_order", g_order, "DIDIDIDIDI");
`else
        chk_s("grant_order", g_order, "DDDDIDDDDI");
`endif

        // Randomized traffic against the model
        do_reset();
        run(600, 35, 35, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/qar_mem_arbiter.md
Name: qar_mem_arbiter

Overview:
- Shares one external memory port between the QAR-Core instruction-fetch (imem_*) and data (mem_*) valid/ready interfaces.
- Lets a single unified SRAM or bus model serve both requesters.
- Registers each transaction through a 3-state FSM, applies fixed data-first priority with an instruction anti-starvation limit, and times out stuck accesses.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- MAX_IWAIT, 4, consecutive data grants allowed while an instruction request waits; the next grant is then forced to instruction. Range 1..15.
- TIMEOUT, 255, cycles in ISSUE without ext_ready before the access is aborted. Range 1..255.
- ERR_RDATA, 32'h0000_0013, read data returned on timeout (NOP encoding).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- imem_valid  in  1  fetch request
- imem_addr  in  ADDR_WIDTH  fetch address
- imem_ready  out  1  one-cycle fetch completion pulse
- imem_rdata  out  DATA_WIDTH  fetch data, valid while imem_ready=1
- mem_valid  in  1  data request
- mem_we  in  1  data write enable
- mem_addr  in  ADDR_WIDTH  data address
- mem_wdata  in  DATA_WIDTH  data write data
- mem_ready  out  1  one-cycle data completion pulse
- mem_rdata  out  DATA_WIDTH  data read data, valid while mem_ready=1
- ext_valid  out  1  shared-port request
- ext_we  out  1  shared-port write enable
- ext_addr  out  ADDR_WIDTH  shared-port address
- ext_wdata  out  DATA_WIDTH  shared-port write data
- ext_ready  in  1  shared-port completion
- ext_rdata  in  DATA_WIDTH  shared-port read data, sampled when ext_ready=1
- owner_d  out  1  1 = current or last grant was data
- bus_err  out  1  sticky timeout flag

Behaviour:
- Single clock domain. rst is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - All outputs 0: ext_valid, ext_we, ext_addr, ext_wdata, imem_ready, mem_ready, imem_rdata, mem_rdata, owner_d, bus_err.
  - iwait_cnt = 0, timer = 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - With any valid asserted, the arbitration winner is selected.
  - Its addr/wdata/we are latched into ext_* and owner_d is set.
  - Next state is ISSUE.
  - imem grants force ext_we = 0.
- Arbitration (default):
  - Data wins over instruction.
  - If imem_valid is high and iwait_cnt == MAX_IWAIT, instruction wins.
  - iwait_cnt increments on each data grant issued while imem_valid is high; it clears on any instruction grant.
  - iwait_cnt saturates at MAX_IWAIT.
- ISSUE:
  - ext_valid = 1; ext_* stay stable.
  - When ext_ready = 1: capture ext_rdata into the owner's rdata register, go to RESP, deassert ext_valid.
  - When ext_ready = 0: timer increments.
  - When timer reaches TIMEOUT-1 without ext_ready: load ERR_RDATA, set bus_err, go to RESP.
- RESP:
  - The owner's ready output is high for exactly one cycle.
  - Next state is IDLE.
  - timer clears.
- Latency with a zero-wait slave:
  - Request is seen in cycle 0; ext_valid is high in cycle 1.
  - ext_ready in cycle 1 gives the upstream ready pulse in cycle 2.
  - Minimum 3 cycles per transaction; back-to-back requests are issued every 3 cycles.
- Requesters hold valid and payload until their ready pulse; the arbiter does not re-sample the payload after IDLE.
- A request that drops valid before being granted is ignored; no error is raised.
- The non-owner's ready stays 0. rdata registers hold their last value outside the ready pulse.
- Simultaneous requests in IDLE are resolved by the arbitration rule. The loser waits; it is never dropped.
- ext_ready while not in ISSUE is ignored.
- bus_err is cleared only by rst.
- rst mid-transaction aborts immediately: outputs return to reset values asynchronously. The slave must tolerate ext_valid dropping without completion.

Optional Feature:
- Macro: QAR_ARB_ROUND_ROBIN_EN.
- Defined:
  - Arbitration is strict alternation. On simultaneous requests the winner is the opposite of the last owner (owner_d).
  - A single requester is always granted.
  - iwait_cnt and MAX_IWAIT are unused; MAX_IWAIT is kept for port compatibility and the counter logic is removed.
- Undefined: data-priority plus anti-starvation as in Behaviour.

Test Plan:
- Fetch only, addr 0x10, slave returns 0x00500093 with 0 wait -> ext_valid high in cycle 1; imem_ready high in cycle 2 with imem_rdata=0x00500093; mem_ready stays 0.
- Data write, addr 0x20, wdata 0xA5A5A5A5, slave with 2 wait cycles -> ext_we=1, ext_addr=0x20 stable for 3 cycles; mem_ready pulses once, 1 cycle after ext_ready.
- imem_valid and mem_valid held high continuously, MAX_IWAIT=4 -> grant order D,D,D,D,I,D,D,D,D,I. With QAR_ARB_ROUND_ROBIN_EN: D,I,D,I alternating after the first grant.
- Slave never asserts ext_ready, TIMEOUT=8 -> after 8 ISSUE cycles, requester ready pulses with rdata=0x00000013; bus_err=1 and stays 1 through later good transactions.
- Assert rst during ISSUE -> ext_valid, ready outputs and bus_err are 0 the same cycle; the next request after rst deassertion completes normally.
- Late ext_ready pulse while in IDLE -> no ready pulse to either requester; state unchanged.
